// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core, with load-use hazard detection and EX flush.
// Optional feature: define BUBBLE_CNT_EN to add the 32-bit BubbleCnt output counting inserted bubbles.
module id_ex_stage #(
   parameter int         DATA_W   = 32,
   parameter int         REG_AW   = 5,
   parameter logic [1:0] LOAD_SRC = 2'b01
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [DATA_W-1:0] PCD,
   input  logic [DATA_W-1:0] PCPlus4D,
   input  logic [DATA_W-1:0] ImmExtD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic [1:0]        ResultSrcD,
   input  logic [2:0]        ALUControlD,
   input  logic              ValidD,
   input  logic              FlushE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] PCE,
   output logic [DATA_W-1:0] PCPlus4E,
   output logic [DATA_W-1:0] ImmExtE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [2:0]        ALUControlE,
   output logic              ValidE,
`ifdef BUBBLE_CNT_EN
   output logic [31:0]       BubbleCnt,
`endif
   output logic              StallD
);

   typedef struct packed {
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pc_plus4;
      logic [DATA_W-1:0] imm_ext;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_write;
      logic              jump;
      logic              branch;
      logic              alu_src;
      logic [1:0]        result_src;
      logic [2:0]        alu_control;
      logic              valid;
   } e_stage_t;

   e_stage_t e_q, e_d;
   logic     load_use;
   logic     bubble;

   // Hazard state lives entirely in the EX copy: once the load moves on, RdE no longer matches.
   assign load_use = e_q.valid && e_q.reg_write && (e_q.result_src == LOAD_SRC)
                     && (e_q.rd != '0) && ValidD
                     && ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

   assign StallD = load_use && !FlushE;
   assign bubble = FlushE || load_use;

   always_comb begin
      // NOTE: default every field first so no path through this block can infer a latch.
      e_d = '0;
      if (!bubble) begin
         e_d.rd1         = RD1D;
         e_d.rd2         = RD2D;
         e_d.pc          = PCD;
         e_d.pc_plus4    = PCPlus4D;
         e_d.imm_ext     = ImmExtD;
         e_d.rs1         = Rs1D;
         e_d.rs2         = Rs2D;
         e_d.rd          = RdD;
         e_d.alu_src     = ALUSrcD;
         e_d.result_src  = ResultSrcD;
         e_d.alu_control = ALUControlD;
         e_d.valid       = ValidD;
         e_d.reg_write   = RegWriteD && ValidD;
         e_d.mem_write   = MemWriteD && ValidD;
         e_d.jump        = JumpD     && ValidD;
         e_d.branch      = BranchD   && ValidD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
      if (!rst_n) e_q <= '0;
      else        e_q <= e_d;
   end

`ifdef BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      bubble_cnt_q <= '0;
      else if (bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
   end

   assign BubbleCnt = bubble_cnt_q;
`endif

   assign RD1E        = e_q.rd1;
   assign RD2E        = e_q.rd2;
   assign PCE         = e_q.pc;
   assign PCPlus4E    = e_q.pc_plus4;
   assign ImmExtE     = e_q.imm_ext;
   assign Rs1E        = e_q.rs1;
   assign Rs2E        = e_q.rs2;
   assign RdE         = e_q.rd;
   assign RegWriteE   = e_q.reg_write;
   assign MemWriteE   = e_q.mem_write;
   assign JumpE       = e_q.jump;
   assign BranchE     = e_q.branch;
   assign ALUSrcE     = e_q.alu_src;
   assign ResultSrcE  = e_q.result_src;
   assign ALUControlE = e_q.alu_control;
   assign ValidE      = e_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a cycle-level reference model of the D->E stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, FlushE;
   logic [1:0]  ResultSrcD;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, StallD;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
`ifdef BUBBLE_CNT_EN
   logic [31:0] BubbleCnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
      .ValidD(ValidD), .FlushE(FlushE),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .ValidE(ValidE),
`ifdef BUBBLE_CNT_EN
      .BubbleCnt(BubbleCnt),
`endif
      .StallD(StallD)
   );

   always #5 clk = ~clk;

   // Reference model: what the E slot should hold, as an instruction record.
   typedef struct {
      logic [31:0] rd1, rd2, pc, pc4, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mw, jmp, br, asrc, valid;
      logic [1:0]  rsrc;
      logic [2:0]  aluc;
   } slot_t;

   slot_t       m;
   logic [31:0] m_bubbles;

   function automatic slot_t empty_slot();
      slot_t s;
      s = '{rd1: 0, rd2: 0, pc: 0, pc4: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
            rw: 0, mw: 0, jmp: 0, br: 0, asrc: 0, valid: 0, rsrc: 0, aluc: 0};
      return s;
   endfunction

   // A real load in EX writing a nonzero register that the real D instruction reads.
   function automatic bit model_load_use();
      bit e_is_load;
      e_is_load = m.valid && m.rw && (m.rsrc == 2'b01) && (m.rd != 0);
      return e_is_load && ValidD && (m.rd == Rs1D || m.rd == Rs2D);
   endfunction

   function automatic void model_edge();
      if (FlushE || model_load_use()) begin
         m = empty_slot();
         m_bubbles = m_bubbles + 1;
      end else begin
         m = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc4: PCPlus4D, imm: ImmExtD,
               rs1: Rs1D, rs2: Rs2D, rd: RdD,
               rw: RegWriteD & ValidD, mw: MemWriteD & ValidD,
               jmp: JumpD & ValidD, br: BranchD & ValidD,
               asrc: ALUSrcD, valid: ValidD, rsrc: ResultSrcD, aluc: ALUControlD};
      end
   endfunction

   function automatic void model_reset();
      m = empty_slot();
      m_bubbles = 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("RD1E", RD1E, m.rd1);
      check("RD2E", RD2E, m.rd2);
      check("PCE", PCE, m.pc);
      check("PCPlus4E", PCPlus4E, m.pc4);
      check("ImmExtE", ImmExtE, m.imm);
      check("Rs1E", 32'(Rs1E), 32'(m.rs1));
      check("Rs2E", 32'(Rs2E), 32'(m.rs2));
      check("RdE", 32'(RdE), 32'(m.rd));
      check("RegWriteE", 32'(RegWriteE), 32'(m.rw));
      check("MemWriteE", 32'(MemWriteE), 32'(m.mw));
      check("JumpE", 32'(JumpE), 32'(m.jmp));
      check("BranchE", 32'(BranchE), 32'(m.br));
      check("ALUSrcE", 32'(ALUSrcE), 32'(m.asrc));
      check("ResultSrcE", 32'(ResultSrcE), 32'(m.rsrc));
      check("ALUControlE", 32'(ALUControlE), 32'(m.aluc));
      check("ValidE", 32'(ValidE), 32'(m.valid));
`ifdef BUBBLE_CNT_EN
      check("BubbleCnt", BubbleCnt, m_bubbles);
`endif
   endtask

   // Called between posedge+1 and the next negedge; exp_stall < 0 means model-only check.
   task automatic cycle(input int exp_stall);
      @(negedge clk);
      check("StallD", 32'(StallD), 32'(model_load_use() && !FlushE));
      if (exp_stall >= 0) check("StallD_directed", 32'(StallD), 32'(exp_stall));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic clear_d();
      RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
      Rs1D = 0; Rs2D = 0; RdD = 0;
      RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
      ResultSrcD = 0; ALUControlD = 0; ValidD = 0; FlushE = 0;
   endtask

   task automatic set_load(input logic [4:0] rd);
      clear_d();
      ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = rd; Rs1D = 5'd2;
      RD1D = 32'h1000; ImmExtD = 32'h4; PCD = 32'h80; PCPlus4D = 32'h84;
   endtask

   task automatic set_capture_vec();
      clear_d();
      ValidD = 1; RD1D = 32'h5; RD2D = 32'hA; RdD = 5'd7; RegWriteD = 1;
      ALUControlD = 3'b010; Rs1D = 5'd1; Rs2D = 5'd3; PCD = 32'h100; PCPlus4D = 32'h104;
   endtask

   task automatic set_random();
      RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      RdD  = 5'($urandom_range(0, 3));
      RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
      BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
      ResultSrcD  = 2'($urandom);
      ALUControlD = 3'($urandom);
      ValidD = ($urandom_range(0, 7) != 0);
      FlushE = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      clear_d();
      model_reset();
      rst_n = 0;
      #2;
      check_outputs();
      check("StallD_reset", 32'(StallD), 32'd0);
      @(posedge clk);
      #1 rst_n = 1;

      // Plain capture
      set_capture_vec();
      cycle(0);
      check("t1_RD1E", RD1E, 32'h5);
      check("t1_RD2E", RD2E, 32'hA);
      check("t1_RdE", 32'(RdE), 32'd7);
      check("t1_ALUControlE", 32'(ALUControlE), 32'b010);
      check("t1_ValidE", 32'(ValidE), 32'd1);

      // Load-use on rs2: one bubble, then the held instruction captures
      set_load(5'd5);
      cycle(0);
      clear_d();
      ValidD = 1; Rs1D = 5'd9; Rs2D = 5'd5; RdD = 5'd6; RegWriteD = 1; RD2D = 32'h55;
      cycle(1);
      check("t2_bubble_ValidE", 32'(ValidE), 32'd0);
      check("t2_bubble_RdE", 32'(RdE), 32'd0);
      cycle(0);
      check("t2_capture_RdE", 32'(RdE), 32'd6);
      check("t2_capture_RD2E", RD2E, 32'h55);

      // Load into x0 never stalls
      set_load(5'd0);
      cycle(0);
      clear_d();
      ValidD = 1; Rs1D = 5'd0; RdD = 5'd4; RegWriteD = 1;
      cycle(0);
      check("t3_RdE", 32'(RdE), 32'd4);

      // Flush and load-use together: no stall, one bubble
      set_load(5'd8);
      cycle(0);
      clear_d();
      ValidD = 1; Rs1D = 5'd8; RdD = 5'd3; RegWriteD = 1; FlushE = 1;
      cycle(0);
      check("t4_ValidE", 32'(ValidE), 32'd0);

      // Async reset while a stall is pending
      set_load(5'd5);
      cycle(0);
      clear_d();
      ValidD = 1; Rs2D = 5'd5;
      @(negedge clk);
      check("t5_stall_before_reset", 32'(StallD), 32'd1);
      #2 rst_n = 0;
      #1;
      model_reset();
      check_outputs();
      check("t5_StallD", 32'(StallD), 32'd0);
      @(posedge clk);
      #1 rst_n = 1;
      set_capture_vec();
      cycle(0);
      check("t5_recapture_RdE", 32'(RdE), 32'd7);

      // Three bubble sources: load-use, flush, flush+load-use
      set_load(5'd5);
      cycle(0);
      clear_d(); ValidD = 1; Rs1D = 5'd5;
      cycle(1);
      cycle(0);
      clear_d(); ValidD = 1; FlushE = 1;
      cycle(0);
      set_load(5'd6);
      cycle(0);
      clear_d(); ValidD = 1; Rs2D = 5'd6; FlushE = 1;
      cycle(0);
`ifdef BUBBLE_CNT_EN
      check("t6_BubbleCnt", BubbleCnt, 32'd3);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         set_random();
         cycle(-1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
